// File: rtl/stream_demux.sv
// Routes one input stream to two independent FWFT FIFO channels (a/b) chosen by sel.
// Optional per-channel pop counters and input stall counter: define STREAM_DEMUX_STATS_EN.

module stream_demux_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         ready,
    output logic [WIDTH-1:0]             data,
    output logic                         valid,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        full  = (count == LW'(DEPTH));
        valid = (count != '0);
        wr_en = push & ~full;
        rd_en = valid & ready;
        data  = valid ? mem[rd_ptr] : '0;
        level = count;
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module stream_demux #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         sysclk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             din,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic                         sel,
    output logic [WIDTH-1:0]             a_data,
    output logic                         a_valid,
    input  logic                         a_ready,
    output logic [WIDTH-1:0]             b_data,
    output logic                         b_valid,
    input  logic                         b_ready,
    output logic [$clog2(DEPTH+1)-1:0]   a_level,
    output logic [$clog2(DEPTH+1)-1:0]   b_level
`ifdef STREAM_DEMUX_STATS_EN
    ,
    output logic [15:0]                  a_beats,
    output logic [15:0]                  b_beats,
    output logic [15:0]                  stall_cnt
`endif
);
    logic a_full;
    logic b_full;
    logic a_push;
    logic b_push;

    // Ready follows only the selected FIFO's fullness; a pop in the same cycle does not help.
    always_comb begin
        din_ready = sel ? ~b_full : ~a_full;
        a_push    = din_valid & din_ready & ~sel;
        b_push    = din_valid & din_ready & sel;
    end

    stream_demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk       (sysclk),
        .rst       (rst),
        .push      (a_push),
        .push_data (din),
        .ready     (a_ready),
        .data      (a_data),
        .valid     (a_valid),
        .full      (a_full),
        .level     (a_level)
    );

    stream_demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk       (sysclk),
        .rst       (rst),
        .push      (b_push),
        .push_data (din),
        .ready     (b_ready),
        .data      (b_data),
        .valid     (b_valid),
        .full      (b_full),
        .level     (b_level)
    );

`ifdef STREAM_DEMUX_STATS_EN
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            a_beats   <= '0;
            b_beats   <= '0;
            stall_cnt <= '0;
        end else begin
            if (a_valid && a_ready && a_beats != '1) begin
                a_beats <= a_beats + 16'd1;
            end
            if (b_valid && b_ready && b_beats != '1) begin
                b_beats <= b_beats + 16'd1;
            end
            if (din_valid && !din_ready && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_stream_demux.sv
// Randomized scoreboard bench for stream_demux: per-channel expected queues filled on
// accepted beats, drained and compared as the channels present data.
`timescale 1ns/1ps

module tb_stream_demux;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH+1);

    logic             sysclk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic             sel = 1'b0;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready = 1'b0;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready = 1'b0;
    logic [LW-1:0]    a_level;
    logic [LW-1:0]    b_level;
`ifdef STREAM_DEMUX_STATS_EN
    logic [15:0]      a_beats;
    logic [15:0]      b_beats;
    logic [15:0]      stall_cnt;
`endif

    stream_demux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sel       (sel),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .a_level   (a_level),
        .b_level   (b_level)
`ifdef STREAM_DEMUX_STATS_EN
        ,
        .a_beats   (a_beats),
        .b_beats   (b_beats),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 sysclk = ~sysclk;

    int checks   = 0;
    int failures = 0;

    bit [WIDTH-1:0] qa[$];
    bit [WIDTH-1:0] qb[$];
    bit             exp_ready = 1'b1;
    bit             prev_rst  = 1'b1;
    logic [15:0]    m_abeats  = '0;
    logic [15:0]    m_bbeats  = '0;
    logic [15:0]    m_stall   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and monitor: rising edges accept beats into the expected queues,
    // falling edges compare the DUT's outputs and retire the heads that are being popped.
    always @(sysclk or rst) begin
        if (rst !== prev_rst) begin
            prev_rst = rst;
            if (rst) begin
                #1;
                check("rst_a_valid", 32'(a_valid), 32'd0);
                check("rst_b_valid", 32'(b_valid), 32'd0);
                check("rst_a_data", 32'(a_data), 32'd0);
                check("rst_b_data", 32'(b_data), 32'd0);
                check("rst_a_level", 32'(a_level), 32'd0);
                check("rst_b_level", 32'(b_level), 32'd0);
                check("rst_din_ready", 32'(din_ready), 32'd1);
                qa.delete();
                qb.delete();
                m_abeats = '0;
                m_bbeats = '0;
                m_stall  = '0;
            end
        end else if (sysclk) begin
            if (!rst) begin
                if (din_valid && exp_ready) begin
                    if (sel) qb.push_back(din);
                    else     qa.push_back(din);
                end
                if (din_valid && !exp_ready && m_stall != 16'hFFFF) m_stall++;
            end
        end else begin
            if (rst) begin
                qa.delete();
                qb.delete();
                m_abeats = '0;
                m_bbeats = '0;
                m_stall  = '0;
            end
            exp_ready = sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
            check("din_ready", 32'(din_ready), 32'(exp_ready));
            check("a_valid", 32'(a_valid), 32'(qa.size() != 0));
            check("a_data", 32'(a_data), (qa.size() != 0) ? 32'(qa[0]) : 32'd0);
            check("a_level", 32'(a_level), 32'(qa.size()));
            check("b_valid", 32'(b_valid), 32'(qb.size() != 0));
            check("b_data", 32'(b_data), (qb.size() != 0) ? 32'(qb[0]) : 32'd0);
            check("b_level", 32'(b_level), 32'(qb.size()));
`ifdef STREAM_DEMUX_STATS_EN
            check("a_beats", 32'(a_beats), 32'(m_abeats));
            check("b_beats", 32'(b_beats), 32'(m_bbeats));
            check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
            if (!rst && a_ready && qa.size() != 0) begin
                void'(qa.pop_front());
                if (m_abeats != 16'hFFFF) m_abeats++;
            end
            if (!rst && b_ready && qb.size() != 0) begin
                void'(qb.pop_front());
                if (m_bbeats != 16'hFFFF) m_bbeats++;
            end
        end
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge sysclk);
        #3 rst = 1'b0;

        // Single beat to channel a with both readies high.
        step();
        din = 8'hFF; sel = 1'b0; din_valid = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
        step();
        din_valid = 1'b0;
        repeat (2) step();

        // Fill channel b while it is stalled, then probe ready for both selections.
        b_ready = 1'b0; sel = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            din = WIDTH'(i); din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        step();
        sel = 1'b0;
        step();
        sel = 1'b1;
        step();

        // Release channel b and let it drain in order.
        b_ready = 1'b1;
        repeat (6) step();

        // Alternate destinations every beat.
        a_ready = 1'b1; b_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sel = i[0]; din = WIDTH'(8'h10 + i); din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        repeat (4) step();

        // Random traffic with a different backpressure bias per phase.
        for (int p = 0; p < 4; p++) begin
            repeat (750) begin
                din       = WIDTH'($urandom);
                sel       = 1'($urandom_range(0, 1));
                din_valid = ($urandom_range(0, 3) != 0);
                a_ready   = ($urandom_range(0, 3) >= p);
                b_ready   = ($urandom_range(0, 3) < (4 - p));
                step();
            end
        end

        // Drain, put two entries in each channel, then reset mid-cycle.
        din_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        repeat (8) step();
        a_ready = 1'b0; b_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel = i[0]; din = WIDTH'(8'hA0 + i); din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        step();
        #2 rst = 1'b1;
        repeat (2) step();
        #2 rst = 1'b0;
        a_ready = 1'b1; b_ready = 1'b1;
        repeat (5) step();

`ifdef STREAM_DEMUX_STATS_EN
        // Stall counting against a full channel b.
        b_ready = 1'b0; sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = WIDTH'(8'hC0 + i); din_valid = 1'b1;
            step();
        end
        repeat (3) step();
        din_valid = 1'b0;
        step();
        #2 rst = 1'b1;
        step();
        #2 rst = 1'b0;

        // Saturation of the channel a pop counter.
        a_ready = 1'b1; b_ready = 1'b1; sel = 1'b0; din_valid = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            din = WIDTH'(i);
            step();
        end
        din_valid = 1'b0;
`endif

        repeat (5) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
